uart_rx_engine: RTL and testbench

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

---
 rtl/uart_rx_engine.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_engine                                                |
// | Brief    : 8x-oversampling UART receiver with majority-vote sampling,    |
// |            valid/ready output holding and overrun reporting.             |
// | Options  : define UART_RX_PARITY_EN to receive one parity bit per char.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_engine #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVISOR_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rx,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    input  logic                     parity_odd,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_error,
    output logic                     parity_error,
    output logic                     overrun
);

    localparam int                     c_BIT_CNT_W = 4;
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT  = c_BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [2:0]             c_PH_S3     = 3'd3;
    localparam logic [2:0]             c_PH_S4     = 3'd4;
    localparam logic [2:0]             c_PH_DECIDE = 3'd5;
    localparam logic [2:0]             c_PH_LAST   = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                     r_sync1;
    logic                     r_sync2;
    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [DIVISOR_WIDTH-1:0] r_tick_cnt;
    logic [2:0]               r_phase;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic                     r_s3;
    logic                     r_s4;
    logic [DATA_WIDTH-1:0]    r_rx_data;
    logic                     r_rx_valid;
    logic                     r_frame_error;
    logic                     r_overrun;

    logic w_line;
    logic w_tick;
    logic w_decide;
    logic w_bit_end;
    logic w_majority;
    logic w_start;
    logic w_shift_en;
    logic w_bit_inc;
    logic w_complete;
    logic w_load;

    assign w_line     = r_sync2;
    assign w_tick     = (r_tick_cnt == '0);
    assign w_decide   = w_tick && (r_phase == c_PH_DECIDE);
    assign w_bit_end  = w_tick && (r_phase == c_PH_LAST);
    assign w_majority = (r_s3 & r_s4) | (r_s3 & w_line) | (r_s4 & w_line);
    assign w_load     = w_complete && (!r_rx_valid || rx_ready);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_error;
    logic w_par_en;
    logic w_parity_bad;

    assign w_parity_bad = ((^r_shift) ^ r_par_bit) != parity_odd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bit      <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            if (w_par_en) r_par_bit <= w_majority;
            if (w_load) r_parity_error <= w_parity_bad;
        end
    end

    assign parity_error = r_parity_error;
`else
    logic w_unused_parity_odd;

    assign w_unused_parity_odd = parity_odd;
    assign parity_error        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_bit_inc   = 1'b0;
        w_complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_line) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                // A high majority means the low level was a glitch.
                if (w_decide && w_majority) w_state_nxt = S_IDLE;
                else if (w_bit_end)         w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_shift_en = w_decide;
                if (w_bit_end) begin
                    w_bit_inc = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_par_en = w_decide;
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Leave mid stop bit so the next start edge is caught promptly.
                if (w_decide) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_tick_cnt <= '0;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_s3       <= 1'b0;
            r_s4       <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;

            if (w_start || w_tick) r_tick_cnt <= divisor;
            else                   r_tick_cnt <= r_tick_cnt - DIVISOR_WIDTH'(1);

            if (w_start) begin
                r_phase   <= '0;
                r_bit_cnt <= '0;
            end else begin
                if (w_tick)    r_phase   <= r_phase + 3'd1;
                if (w_bit_inc) r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
            end

            if (w_tick && (r_phase == c_PH_S3)) r_s3 <= w_line;
            if (w_tick && (r_phase == c_PH_S4)) r_s4 <= w_line;

            if (w_shift_en) r_shift <= {w_majority, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_rx_data     <= r_shift;
                r_frame_error <= ~w_majority;
                r_rx_valid    <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_engine                                             |
// | Brief    : Scoreboard bench for uart_rx_engine (honours UART_RX_PARITY_EN)|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_engine;

    localparam int c_DW = 8;

    typedef struct packed {
        logic [c_DW-1:0] data;
        logic            fe;
        logic            pe;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            uart_rx = 1'b1;
    logic [15:0]     divisor = 16'd0;
    logic            parity_odd = 1'b0;
    logic [c_DW-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ready = 1'b1;
    logic            frame_error;
    logic            parity_error;
    logic            overrun;

    int   tests = 0;
    int   fails = 0;
    int   ovr_cnt = 0;
    int   exp_ovr = 0;
    exp_t exp_q[$];
    logic r_prev_valid = 1'b0;
    logic r_prev_hs = 1'b0;

    uart_rx_engine #(.DATA_WIDTH(c_DW), .DIVISOR_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .divisor      (divisor),
        .parity_odd   (parity_odd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference model: character fields straight from the frame contents.
    task automatic push_exp(input logic [c_DW-1:0] data, input logic stop_bit, input logic par_bit);
        exp_t e;
        e.data = data;
        e.fe   = ~stop_bit;
`ifdef UART_RX_PARITY_EN
        e.pe   = ((^data) ^ par_bit) != parity_odd;
`else
        e.pe   = 1'b0;
        if (par_bit === 1'bx) e.pe = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    // Drives start, data LSB first, optional parity, stop, then two idle bit times.
    task automatic send_frame(input logic [c_DW-1:0] data, input logic stop_bit,
                              input logic par_bit, input int d);
        logic [15:0] bits;
        int          n;
        bits = '0;
        n    = 1;
        for (int i = 0; i < c_DW; i++) begin
            bits[n] = data[i];
            n++;
        end
`ifdef UART_RX_PARITY_EN
        bits[n] = par_bit;
        n++;
`endif
        bits[n] = stop_bit;
        n++;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 uart_rx = bits[i];
            repeat (8 * (d + 1) - 1) @(posedge clk);
        end
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (16 * (d + 1) - 1) @(posedge clk);
    endtask

    // Scoreboard monitor: a character is presented when rx_valid is seen after
    // either an empty holding stage or a handshake in the previous cycle.
    always @(negedge clk) begin
        if (reset) begin
            r_prev_valid = 1'b0;
            r_prev_hs    = 1'b0;
        end else begin
            if (overrun === 1'b1) ovr_cnt++;
            if (rx_valid === 1'b1 && (!r_prev_valid || r_prev_hs)) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL char_unexpected: got data=%0h fe=%0b pe=%0b, expected no character",
                             rx_data, frame_error, parity_error);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rx_data !== e.data || frame_error !== e.fe || parity_error !== e.pe) begin
                        fails++;
                        $display("FAIL char: got data=%0h fe=%0b pe=%0b, expected data=%0h fe=%0b pe=%0b",
                                 rx_data, frame_error, parity_error, e.data, e.fe, e.pe);
                    end
                end
            end
            r_prev_valid = (rx_valid === 1'b1);
            r_prev_hs    = (rx_valid === 1'b1) && rx_ready;
        end
    end

    initial begin
        int o0;
        int n_ready;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_error", 32'(frame_error), 32'h0);
        check("reset_parity_error", 32'(parity_error), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // Basic reception, then handshake clears valid but keeps data.
        #1 divisor = 16'd0; rx_ready = 1'b0;
        push_exp(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("valid_after_0x55", 32'(rx_valid), 32'h1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_cleared", 32'(rx_valid), 32'h0);
        check("data_retained", 32'(rx_data), 32'h55);

        // Short glitch must be rejected as a false start.
        @(posedge clk); #1 divisor = 16'd3; uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (3 * 32) @(posedge clk);
        @(negedge clk);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        push_exp(8'hC6, 1'b1, 1'b1);
        send_frame(8'hC6, 1'b1, 1'b1, 3);

        // Framing error.
        @(posedge clk); #1 divisor = 16'd0;
        push_exp(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b0, 0);

`ifdef UART_RX_PARITY_EN
        @(posedge clk); #1 parity_odd = 1'b0;
        push_exp(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        push_exp(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, 0);
`endif

        // Overrun, then consume coinciding with a completion.
        repeat (4) @(posedge clk);
        #1 rx_ready = 1'b0;
        push_exp(8'h11, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 0);
        o0 = ovr_cnt;
        exp_ovr++;
        send_frame(8'h22, 1'b1, 1'b0, 0);
        check("overrun_pulse_count", 32'(ovr_cnt), 32'(o0 + 1));
        @(negedge clk);
        check("held_after_overrun", 32'(rx_data), 32'h11);
        o0 = ovr_cnt;
`ifdef UART_RX_PARITY_EN
        n_ready = 3 + (8 * (c_DW + 2) + 6);
`else
        n_ready = 3 + (8 * (c_DW + 1) + 6);
`endif
        push_exp(8'h33, 1'b1, 1'b0);
        fork
            send_frame(8'h33, 1'b1, 1'b0, 0);
            begin
                @(posedge clk);
                repeat (n_ready - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
            end
        join
        check("no_overrun_on_consume", 32'(ovr_cnt), 32'(o0));

        // Reset in the middle of 0x5A (during data bit 4), then 0x3C.
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (7) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 uart_rx = (8'h5A >> i) & 1'b1;
            repeat (8) @(posedge clk);
        end
        #1 uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);

        // Randomized frames against the reference model.
        for (int k = 0; k < 20; k++) begin
            logic [c_DW-1:0] rd;
            logic            rs;
            logic            rp;
            int              rdiv;
            rdiv = int'($urandom_range(0, 3));
            rd   = c_DW'($urandom);
            rs   = ($urandom_range(0, 3) != 0);
            rp   = 1'($urandom);
            @(posedge clk); #1 divisor = 16'(rdiv); parity_odd = 1'($urandom);
            push_exp(rd, rs, rp);
            send_frame(rd, rs, rp, rdiv);
        end

        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check("overrun_total", 32'(ovr_cnt), 32'(exp_ovr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
